dsm_result_packer: RTL and testbench



---
 rtl/dsm_result_packer.sv | 216 +++++++++++++++++++++
 tb/tb_dsm_result_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_result_packer.sv
// -----------------------------------------------------------------------------
// dsm_result_packer
//
// Purpose:
//   Collects per-channel high/low time results from the digital-signal-measure
//   stage and serializes each one as a fixed-format byte frame on a valid/ready
//   byte stream. A rising edge on measure_done[ch] captures that channel's times
//   into a holding register and marks it pending. A round-robin arbiter then
//   picks pending channels one at a time and emits their frames.
//
// Frame layout:
//   byte 0 : HEADER_BYTE
//   byte 1 : {ovr, 3'b000, ch[3:0]}   ovr = a captured result was overwritten
//   byte 2 : high[15:8]   byte 3 : high[7:0]
//   byte 4 : low[15:8]    byte 5 : low[7:0]
//   byte 6 : (byte1+...+byte5) mod 256, only when DSM_PACK_CHECKSUM_EN is defined
//
// Configuration macro:
//   DSM_PACK_CHECKSUM_EN  - appends the checksum byte (7-byte frames).
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   high_time     in   NUM_CHANNELS*16, channel ch at [ch*16+15:ch*16]
//   low_time      in   NUM_CHANNELS*16, same packing
//   measure_done  in   NUM_CHANNELS per-channel done level
//   upload_data   out  frame byte
//   upload_valid  out  upload_data is valid
//   upload_ready  in   sink ready
//   busy          out  frame in flight (FSM is in SEND)
//   pending       out  per-channel "captured, not yet framed" flags
//
// Handshake: a byte transfers on a clock edge where upload_valid && upload_ready.
// While upload_valid is high and upload_ready is low, upload_data and
// upload_valid hold their values; upload_valid never drops without a transfer
// except on reset.
// -----------------------------------------------------------------------------
module dsm_result_packer #(
   parameter int         NUM_CHANNELS = 8,
   parameter logic [7:0] HEADER_BYTE  = 8'hAA
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CHANNELS*16-1:0] high_time,
   input  logic [NUM_CHANNELS*16-1:0] low_time,
   input  logic [NUM_CHANNELS-1:0]    measure_done,
   output logic [7:0]                 upload_data,
   output logic                       upload_valid,
   input  logic                       upload_ready,
   output logic                       busy,
   output logic [NUM_CHANNELS-1:0]    pending
);

`ifdef DSM_PACK_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd6;
`else
   localparam logic [2:0] LAST_IDX = 3'd5;
`endif

   typedef enum logic {IDLE, SEND} state_e;

   state_e                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic [3:0]              rr_q, rr_d;
   logic [NUM_CHANNELS-1:0] done_q, rise;
   logic [NUM_CHANNELS-1:0] pending_q, pending_d;
   logic [NUM_CHANNELS-1:0] ovr_q, ovr_d;
   logic [NUM_CHANNELS-1:0] clr_mask;
   logic [15:0]             hold_hi_q [NUM_CHANNELS];
   logic [15:0]             hold_lo_q [NUM_CHANNELS];

   logic [15:0]             fr_hi_q, fr_lo_q;
   logic [3:0]              fr_ch_q;
   logic                    fr_ovr_q;

   logic                    start;
   logic                    sel_found;
   logic [3:0]              sel_ch;
   logic [15:0]             sel_hi, sel_lo;
   logic                    sel_ovr;
   logic [NUM_CHANNELS-1:0] rot;
   logic [4:0]              sum5;
   logic [7:0]              byte1, frame_byte;

   assign rise    = measure_done & ~done_q;
   assign pending = pending_q;

   // Round-robin pick: rotate pending so rr lands at bit 0, take the lowest
   // set bit, then map the offset back to a channel number.
   always_comb begin
      rot       = NUM_CHANNELS'({pending_q, pending_q} >> rr_q);
      sel_found = 1'b0;
      sum5      = '0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel_found = 1'b1;
            sum5      = {1'b0, rr_q} + 5'(k);
         end
      end
      sel_ch = (sum5 >= 5'(NUM_CHANNELS)) ? 4'(sum5 - 5'(NUM_CHANNELS)) : 4'(sum5);
   end

   always_comb begin
      sel_hi  = '0;
      sel_lo  = '0;
      sel_ovr = 1'b0;
      for (int j = 0; j < NUM_CHANNELS; j++) begin
         if (sel_ch == 4'(j)) begin
            sel_hi  = hold_hi_q[j];
            sel_lo  = hold_lo_q[j];
            sel_ovr = ovr_q[j];
         end
      end
   end

   always_comb begin
      byte1      = {fr_ovr_q, 3'b000, fr_ch_q};
      frame_byte = 8'h00;
      case (idx_q)
         3'd0:    frame_byte = HEADER_BYTE;
         3'd1:    frame_byte = byte1;
         3'd2:    frame_byte = fr_hi_q[15:8];
         3'd3:    frame_byte = fr_hi_q[7:0];
         3'd4:    frame_byte = fr_lo_q[15:8];
         3'd5:    frame_byte = fr_lo_q[7:0];
`ifdef DSM_PACK_CHECKSUM_EN
         3'd6:    frame_byte = byte1 + fr_hi_q[15:8] + fr_hi_q[7:0]
                               + fr_lo_q[15:8] + fr_lo_q[7:0];
`endif
         default: frame_byte = 8'h00;
      endcase
   end

   // FSM next state and outputs
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rr_d         = rr_q;
      start        = 1'b0;
      upload_valid = 1'b0;
      upload_data  = 8'h00;
      busy         = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               start   = 1'b1;
               state_d = SEND;
               idx_d   = 3'd0;
               rr_d    = ({1'b0, sel_ch} + 5'd1 == 5'(NUM_CHANNELS)) ? 4'd0 : sel_ch + 4'd1;
            end
         end
         SEND: begin
            upload_valid = 1'b1;
            busy         = 1'b1;
            upload_data  = frame_byte;
            if (upload_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture sets after frame-start clears, so a coincident capture keeps the
   // channel pending and its overrun mark.
   always_comb begin
      for (int j = 0; j < NUM_CHANNELS; j++) begin
         clr_mask[j] = start && (sel_ch == 4'(j));
      end
      pending_d = (pending_q & ~clr_mask) | rise;
      ovr_d     = (ovr_q & ~clr_mask) | (rise & pending_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rr_q      <= '0;
         done_q    <= '0;
         pending_q <= '0;
         ovr_q     <= '0;
         fr_hi_q   <= '0;
         fr_lo_q   <= '0;
         fr_ch_q   <= '0;
         fr_ovr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rr_q      <= rr_d;
         done_q    <= measure_done;
         pending_q <= pending_d;
         ovr_q     <= ovr_d;
         if (start) begin
            fr_hi_q  <= sel_hi;
            fr_lo_q  <= sel_lo;
            fr_ch_q  <= sel_ch;
            fr_ovr_q <= sel_ovr;
         end
      end
   end

   // Holding registers carry no reset: they are only read once pending is set.
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (rise[ch]) begin
            hold_hi_q[ch] <= high_time[ch*16 +: 16];
            hold_lo_q[ch] <= low_time[ch*16 +: 16];
         end
      end
   end

endmodule

// File: tb/tb_dsm_result_packer.sv
`timescale 1ns/1ps
module tb_dsm_result_packer;

   localparam int NCH = 8;
`ifdef DSM_PACK_CHECKSUM_EN
   localparam int FL = 7;
`else
   localparam int FL = 6;
`endif

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH*16-1:0]    high_time = '0;
   logic [NCH*16-1:0]    low_time = '0;
   logic [NCH-1:0]       measure_done = '0;
   logic [7:0]           upload_data;
   logic                 upload_valid;
   logic                 upload_ready = 1'b0;
   logic                 busy;
   logic [NCH-1:0]       pending;

   always #5 clk = ~clk;

   dsm_result_packer #(.NUM_CHANNELS(NCH), .HEADER_BYTE(8'hAA)) dut (
      .clk          (clk),
      .rst          (rst),
      .high_time    (high_time),
      .low_time     (low_time),
      .measure_done (measure_done),
      .upload_data  (upload_data),
      .upload_valid (upload_valid),
      .upload_ready (upload_ready),
      .busy         (busy),
      .pending      (pending)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per-channel result slots plus a "frame in flight" byte counter. At each
   // edge the model decides frame start from its own state and the ready
   // input, and pushes the whole frame's bytes into exp_q when it starts.
   int          m_hi[NCH];
   int          m_lo[NCH];
   bit          m_pend[NCH];
   bit          m_ovr[NCH];
   bit          m_old_pend[NCH];
   logic [NCH-1:0] m_prev = '0;
   int          m_rr = 0;
   int          m_left = 0;
   int          m_pick;
   int          m_c;
   int          m_sum;
   logic [7:0]  m_f[7];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
         end
         m_prev = '0;
         m_rr   = 0;
         m_left = 0;
         exp_q.delete();
      end else begin
         m_old_pend = m_pend;
         if (m_left > 0) begin
            if (upload_ready) m_left--;
         end else begin
            m_pick = -1;
            for (int k = 0; k < NCH; k++) begin
               m_c = (m_rr + k) % NCH;
               if (m_pick < 0 && m_pend[m_c]) m_pick = m_c;
            end
            if (m_pick >= 0) begin
               m_f[0] = 8'hAA;
               m_f[1] = 8'(m_ovr[m_pick] * 128 + m_pick);
               m_f[2] = 8'(m_hi[m_pick] / 256);
               m_f[3] = 8'(m_hi[m_pick] % 256);
               m_f[4] = 8'(m_lo[m_pick] / 256);
               m_f[5] = 8'(m_lo[m_pick] % 256);
               m_sum = 0;
               for (int k = 1; k <= 5; k++) m_sum += m_f[k];
               m_f[6] = 8'(m_sum % 256);
               for (int k = 0; k < FL; k++) exp_q.push_back(m_f[k]);
               m_pend[m_pick] = 1'b0;
               m_ovr[m_pick]  = 1'b0;
               m_rr   = (m_pick + 1) % NCH;
               m_left = FL;
            end
         end
         for (int ch = 0; ch < NCH; ch++) begin
            if (measure_done[ch] && !m_prev[ch]) begin
               if (m_old_pend[ch]) m_ovr[ch] = 1'b1;
               m_pend[ch] = 1'b1;
               m_hi[ch] = int'(high_time[ch*16 +: 16]);
               m_lo[ch] = int'(low_time[ch*16 +: 16]);
            end
         end
         m_prev = measure_done;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [NCH-1:0] m_pvec;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < NCH; i++) m_pvec[i] = m_pend[i];
         check("pending", 32'(pending), 32'(m_pvec));
         check("upload_valid", 32'(upload_valid), 32'(m_left > 0));
         check("busy", 32'(busy), 32'(m_left > 0));
         if (upload_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got %0h expected none at %0t", upload_data, $time);
            end else begin
               check("upload_data", 32'(upload_data), 32'(exp_q[0]));
               if (upload_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ch(input int ch, input logic [15:0] hi, input logic [15:0] lo);
      high_time[ch*16 +: 16] = hi;
      low_time[ch*16 +: 16]  = lo;
   endtask

   task automatic pulse(input int ch, input logic [15:0] hi, input logic [15:0] lo);
      set_ch(ch, hi, lo);
      measure_done[ch] = 1'b1;
      step(1);
      measure_done[ch] = 1'b0;
      step(1);
   endtask

   task automatic wait_left(input int target);
      int g;
      g = 0;
      while (m_left != target && g < 100) begin
         step(1);
         g++;
      end
      if (m_left != target) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_left: got %0d expected %0d", m_left, target);
      end
   endtask

   int bp_pat[4] = '{1, 0, 0, 1};

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      step(3);
      check("reset_upload_data", 32'(upload_data), 32'h0);
      check("reset_upload_valid", 32'(upload_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_pending", 32'(pending), 32'h0);
      mon_en = 1'b1;
      rst = 1'b0;
      step(2);

      // single capture on ch2
      upload_ready = 1'b1;
      pulse(2, 16'h1234, 16'h5678);
      step(12);

      // backpressure on the same frame contents
      pulse(2, 16'h1234, 16'h5678);
      for (int i = 0; i < 40; i++) begin
         upload_ready = bp_pat[i % 4][0];
         step(1);
      end
      upload_ready = 1'b1;
      step(5);

      // overrun on ch0 while a ch1 frame is stalled
      upload_ready = 1'b0;
      pulse(1, 16'h1111, 16'h2222);
      pulse(0, 16'h0001, 16'h0002);
      pulse(0, 16'h0003, 16'h0004);
      step(2);
      upload_ready = 1'b1;
      step(25);

      // round robin: ch5 frame leaves rr at 6, then ch1/ch5/ch7 together
      pulse(5, 16'h5555, 16'h0505);
      step(10);
      set_ch(1, 16'hA001, 16'hB001);
      set_ch(5, 16'hA005, 16'hB005);
      set_ch(7, 16'hA007, 16'hB007);
      measure_done = 8'b1010_0010;
      step(1);
      measure_done = '0;
      step(30);

      // set-beats-clear on ch3
      upload_ready = 1'b0;
      pulse(6, 16'h6666, 16'h0606);
      step(2);
      pulse(3, 16'h3333, 16'h4444);
      upload_ready = 1'b1;
      wait_left(1);
      step(1);
      pulse(3, 16'hBEEF, 16'hCAFE);
      step(25);

      // level held high captures once
      set_ch(0, 16'h0F0F, 16'hF0F0);
      measure_done[0] = 1'b1;
      step(20);
      measure_done[0] = 1'b0;
      step(5);

      // reset mid-frame with another result pending
      upload_ready = 1'b0;
      pulse(4, 16'h4444, 16'h4040);
      pulse(6, 16'h6060, 16'h6161);
      upload_ready = 1'b1;
      wait_left(FL - 3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(10);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 5) == 0) measure_done[c] = ~measure_done[c];
            set_ch(c, 16'($urandom), 16'($urandom));
         end
         upload_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end

      // drain
      measure_done = '0;
      upload_ready = 1'b1;
      step(200);
      check("exp_q_empty", 32'(exp_q.size()), 32'h0);
      check("final_valid", 32'(upload_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
